rgb_block_sequencer: RTL and testbench

RGB_BLOCK_SEQUENCER -- requirements
Module: rgb_block_sequencer

---
 rtl/rgb_block_sequencer.sv | 131 +++++++++++++
 tb/tb_rgb_block_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_block_sequencer.sv
// Sequences one 8x8 RGB block through an external rgb2ycbcr converter:
// read pixel, load operands, wait for the converter, write the YCbCr result.
module rgb_block_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blk_start,
  output logic        pix_rd_en,
  output logic [5:0]  pix_rd_addr,
  input  logic [23:0] pix_rd_data,
  output logic        conv_start,
  output logic [7:0]  conv_R,
  output logic [7:0]  conv_G,
  output logic [7:0]  conv_B,
  input  logic [7:0]  conv_Y,
  input  logic [7:0]  conv_Cb,
  input  logic [7:0]  conv_Cr,
  input  logic        conv_done,
  output logic        ycc_wr_en,
  output logic [5:0]  ycc_wr_addr,
  output logic [23:0] ycc_wr_data,
  output logic        busy,
  output logic        blk_done,
  output logic        err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [23:0]   rgb_q;
  logic [23:0]   ycc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      rgb_q   <= '0;
      ycc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      if (state_q == S_LOAD)
        rgb_q <= pix_rd_data;
      if (state_q == S_WAIT && conv_done)
        ycc_q <= {conv_Y, conv_Cb, conv_Cr};
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (blk_start) begin
          state_d = S_READ;
          idx_d   = '0;
        end
      end
      S_READ:  state_d = S_LOAD;
      S_LOAD: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving in the final counted cycle still beats the timeout.
        if (conv_done) begin
          state_d = S_WRITE;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_d == CW'(TIMEOUT))
            state_d = S_ERR;
        end
      end
      S_WRITE: begin
        if (idx_q == 6'd63) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pix_rd_en   = (state_q == S_READ);
    pix_rd_addr = (state_q == S_READ) ? idx_q : 6'd0;
    conv_start  = (state_q == S_LOAD);
    // Operands come straight from the buffer during LOAD so they are valid
    // alongside conv_start, then hold from the captured copy.
    if (state_q == S_LOAD) begin
      conv_R = pix_rd_data[23:16];
      conv_G = pix_rd_data[15:8];
      conv_B = pix_rd_data[7:0];
    end else begin
      conv_R = rgb_q[23:16];
      conv_G = rgb_q[15:8];
      conv_B = rgb_q[7:0];
    end
    ycc_wr_en   = (state_q == S_WRITE);
    ycc_wr_addr = (state_q == S_WRITE) ? idx_q : 6'd0;
    ycc_wr_data = (state_q == S_WRITE) ? ycc_q : 24'd0;
    busy        = (state_q != S_IDLE);
    blk_done    = (state_q == S_DONE);
    err         = (state_q == S_ERR);
  end

endmodule

// File: tb/tb_rgb_block_sequencer.sv
// Directed bench for rgb_block_sequencer with a pixel-buffer model and a
// fixed-latency rgb2ycbcr converter model.
module tb_rgb_block_sequencer;

  localparam int TIMEOUT = 15;
  localparam int LAT     = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        blk_start = 1'b0;
  logic        pix_rd_en;
  logic [5:0]  pix_rd_addr;
  logic [23:0] pix_rd_data = '0;
  logic        conv_start;
  logic [7:0]  conv_R, conv_G, conv_B;
  logic [7:0]  conv_Y = '0, conv_Cb = '0, conv_Cr = '0;
  logic        conv_done;
  logic        ycc_wr_en;
  logic [5:0]  ycc_wr_addr;
  logic [23:0] ycc_wr_data;
  logic        busy, blk_done, err;

  logic        model_done = 1'b0;
  bit          force_done = 1'b0;
  bit          stall = 1'b0;
  assign conv_done = model_done | force_done;

  rgb_block_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .blk_start(blk_start),
    .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
    .conv_start(conv_start), .conv_R(conv_R), .conv_G(conv_G), .conv_B(conv_B),
    .conv_Y(conv_Y), .conv_Cb(conv_Cb), .conv_Cr(conv_Cr), .conv_done(conv_done),
    .ycc_wr_en(ycc_wr_en), .ycc_wr_addr(ycc_wr_addr), .ycc_wr_data(ycc_wr_data),
    .busy(busy), .blk_done(blk_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] mem [64];
  int          pending = 0;
  logic [23:0] cap_rgb = '0;

  int          n_wr = 0, n_done = 0, n_err = 0, n_rd = 0;
  int          done_cyc = 0, err_cyc = 0, start_cyc = 0;
  logic [5:0]  first_rd_addr = '0, last_rd_addr = '0;
  logic [5:0]  wr_addr [128];
  logic [23:0] wr_data [128];
  int          wr_cyc  [128];

  function automatic logic [23:0] ycc_of(input logic [23:0] rgb);
    int r, g, b, y, cb, cr;
    r  = int'(rgb[23:16]);
    g  = int'(rgb[15:8]);
    b  = int'(rgb[7:0]);
    y  = (77 * r + 150 * g + 29 * b) >>> 8;
    cb = ((-43 * r - 85 * g + 128 * b) >>> 8) + 128;
    cr = ((128 * r - 107 * g - 21 * b) >>> 8) + 128;
    if (y > 255) y = 255;
    if (cb > 255) cb = 255;
    if (cr > 255) cr = 255;
    if (cb < 0) cb = 0;
    if (cr < 0) cr = 0;
    return {y[7:0], cb[7:0], cr[7:0]};
  endfunction

  // Buffer, converter and monitor all act mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pending    = 0;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (pending != 0) begin
        pending = pending - 1;
        if (pending == 0) begin
          model_done = 1'b1;
          {conv_Y, conv_Cb, conv_Cr} = ycc_of(cap_rgb);
        end
      end
      if (conv_start && !stall) begin
        pending = LAT;
        cap_rgb = {conv_R, conv_G, conv_B};
      end
    end
    if (pix_rd_en) begin
      pix_rd_data = mem[pix_rd_addr];
      if (n_rd == 0) first_rd_addr = pix_rd_addr;
      last_rd_addr = pix_rd_addr;
      n_rd++;
    end
    if (conv_start) start_cyc = cyc;
    if (ycc_wr_en && n_wr < 128) begin
      wr_addr[n_wr] = ycc_wr_addr;
      wr_data[n_wr] = ycc_wr_data;
      wr_cyc[n_wr]  = cyc;
      n_wr++;
    end
    if (blk_done) begin n_done++; done_cyc = cyc; end
    if (err)      begin n_err++;  err_cyc  = cyc; end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_wr = 0; n_done = 0; n_err = 0; n_rd = 0;
  endtask

  task automatic fill(input logic [23:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  task automatic start_block(output int s);
    blk_start = 1'b1;
    s = cyc;
    tick();
    blk_start = 1'b0;
  endtask

  task automatic run_until_end(input int budget, output bit timed_out);
    int k = 0;
    while (n_done == 0 && n_err == 0 && k < budget) begin
      tick();
      k++;
    end
    timed_out = (k >= budget);
  endtask

  task automatic wait_reads(input int n, input int budget);
    int k = 0;
    while (n_rd < n && k < budget) begin
      tick();
      k++;
    end
    vectors++;
    if (n_rd < n) begin
      miscompares++;
      $display("FAIL wait_reads: reads=%0d required=%0d", n_rd, n);
    end
  endtask

  task automatic test_reset();
    logic [91:0] outs;
    rst_n = 1'b0;
    repeat (3) tick();
    outs = {pix_rd_en, pix_rd_addr, conv_start, conv_R, conv_G, conv_B,
            ycc_wr_en, ycc_wr_addr, ycc_wr_data, busy, blk_done, err};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got=%h required=0", outs);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    vectors++;
    if (busy !== 1'b0 || pix_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b rd_en=%b required=0,0", busy, pix_rd_en);
    end
  endtask

  task automatic test_block(input string name, input logic [23:0] exp [64]);
    int s, bad_addr, bad_data, bad_cyc;
    bit to;
    clear_mon();
    start_block(s);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_busy_rise: got=%b required=1", name, busy);
    end
    run_until_end(500, to);
    vectors++;
    if (to || n_done !== 1 || n_err !== 0) begin
      miscompares++;
      $display("FAIL %s_completion: timeout=%0d done=%0d err=%0d required 0,1,0", name, to, n_done, n_err);
    end
    vectors++;
    if (n_wr !== 64) begin
      miscompares++;
      $display("FAIL %s_write_count: got=%0d required=64", name, n_wr);
    end
    bad_addr = 0; bad_data = 0; bad_cyc = 0;
    for (int i = 0; i < 64 && i < n_wr; i++) begin
      if (wr_addr[i] !== 6'(i)) bad_addr++;
      if (wr_data[i] !== exp[i]) bad_data++;
      if (wr_cyc[i] !== s + 6 + 6 * i) bad_cyc++;
    end
    vectors++;
    if (bad_addr != 0) begin
      miscompares++;
      $display("FAIL %s_write_order: %0d bad addresses, required 0", name, bad_addr);
    end
    vectors++;
    if (bad_data != 0) begin
      miscompares++;
      $display("FAIL %s_write_data: %0d bad words, required 0", name, bad_data);
    end
    vectors++;
    if (bad_cyc != 0) begin
      miscompares++;
      $display("FAIL %s_pixel_latency: %0d pixels off 6-cycle cadence, required 0", name, bad_cyc);
    end
    vectors++;
    if (done_cyc !== s + 385) begin
      miscompares++;
      $display("FAIL %s_done_latency: got=%0d required=%0d", name, done_cyc - s, 385);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || blk_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_busy_fall: busy=%b done=%b required 0,0", name, busy, blk_done);
    end
  endtask

  task automatic test_uniform_block();
    logic [23:0] exp [64];
    fill(24'h808080);
    for (int i = 0; i < 64; i++) exp[i] = 24'h808080;
    test_block("uniform", exp);
  endtask

  task automatic test_colour_pixels();
    logic [23:0] exp [64];
    fill(24'h808080);
    mem[5] = 24'hFF0000;
    mem[9] = 24'hFFFFFF;
    for (int i = 0; i < 64; i++) exp[i] = 24'h808080;
    exp[5] = {8'd76, 8'd85, 8'd255};
    exp[9] = {8'd255, 8'd128, 8'd128};
    test_block("colour", exp);
    vectors++;
    if (n_wr > 9 && (wr_data[5] !== 24'h4C55FF || wr_data[9] !== 24'hFF8080)) begin
      miscompares++;
      $display("FAIL colour_pixels: px5=%h px9=%h required 4c55ff ff8080", wr_data[5], wr_data[9]);
    end
  endtask

  task automatic test_timeout();
    int s;
    bit to;
    fill(24'h808080);
    stall = 1'b1;
    clear_mon();
    start_block(s);
    run_until_end(100, to);
    vectors++;
    if (to || n_err !== 1) begin
      miscompares++;
      $display("FAIL timeout_err: timeout=%0d err=%0d required 0,1", to, n_err);
    end
    vectors++;
    if (err_cyc !== start_cyc + 1 + TIMEOUT) begin
      miscompares++;
      $display("FAIL timeout_delay: got=%0d required=%0d", err_cyc - start_cyc - 1, TIMEOUT);
    end
    tick();
    vectors++;
    if (n_wr !== 0 || n_done !== 0 || busy !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_after: wr=%0d done=%0d busy=%b err=%b required 0,0,0,0", n_wr, n_done, busy, err);
    end
    stall = 1'b0;
  endtask

  task automatic test_back_to_back();
    int s;
    bit to;
    fill(24'h808080);
    clear_mon();
    start_block(s);
    wait_reads(21, 200);
    blk_start = 1'b1;
    tick();
    blk_start = 1'b0;
    run_until_end(500, to);
    repeat (12) tick();
    vectors++;
    if (to || n_wr !== 64 || n_done !== 1 || n_rd !== 64 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_ignored: wr=%0d done=%0d rd=%0d busy=%b required 64,1,64,0", n_wr, n_done, n_rd, busy);
    end
  endtask

  task automatic test_reset_mid_block();
    int s;
    bit to;
    logic [91:0] outs;
    fill(24'h808080);
    clear_mon();
    start_block(s);
    wait_reads(31, 300);
    tick();
    tick();
    vectors++;
    if (conv_R !== 8'd128 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_state: conv_R=%0d busy=%b required 128,1", conv_R, busy);
    end
    rst_n = 1'b0;
    #1;
    outs = {pix_rd_en, pix_rd_addr, conv_start, conv_R, conv_G, conv_B,
            ycc_wr_en, ycc_wr_addr, ycc_wr_data, busy, blk_done, err};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got=%h required=0", outs);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    vectors++;
    if (n_done !== 0 || n_err !== 0 || n_wr !== 30) begin
      miscompares++;
      $display("FAIL reset_abandon: done=%0d err=%0d wr=%0d required 0,0,30", n_done, n_err, n_wr);
    end
    clear_mon();
    start_block(s);
    wait_reads(1, 10);
    vectors++;
    if (first_rd_addr !== 6'd0) begin
      miscompares++;
      $display("FAIL restart_addr: got=%0d required=0", first_rd_addr);
    end
    run_until_end(500, to);
    vectors++;
    if (to || n_wr !== 64 || n_done !== 1) begin
      miscompares++;
      $display("FAIL restart_block: wr=%0d done=%0d required 64,1", n_wr, n_done);
    end
    tick();
  endtask

  task automatic test_spurious_done();
    int s, r;
    bit to;
    fill(24'h808080);
    clear_mon();
    start_block(s);
    wait_reads(8, 100);
    r = cyc;
    force_done = 1'b1;
    tick();
    tick();
    force_done = 1'b0;
    run_until_end(500, to);
    vectors++;
    if (to || n_wr !== 64 || n_done !== 1) begin
      miscompares++;
      $display("FAIL spurious_count: wr=%0d done=%0d required 64,1", n_wr, n_done);
    end
    vectors++;
    if (n_wr > 7 && (wr_addr[7] !== 6'd7 || wr_cyc[7] !== r + 5 || wr_data[7] !== 24'h808080)) begin
      miscompares++;
      $display("FAIL spurious_px7: addr=%0d at=%0d data=%h required 7,%0d,808080", wr_addr[7], wr_cyc[7] - r, wr_data[7], 5);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_uniform_block();
    test_colour_pixels();
    test_timeout();
    test_back_to_back();
    test_reset_mid_block();
    test_spurious_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
